rvfi_trace_buffer: RTL and testbench
====================================

// Module: rvfi_trace_buffer
// PURPOSE
// - Synthesizable on-chip retirement trace capture for the rv32i core. Taps the RVFI
//   retirement signals in the data path (WB stage) and stores retired-instruction records
//   in a circular buffer. The bench or a debug master drains the buffer over a valid/ready port.
// - Supports NRET retire lanes, FIFO or ring capture modes, a PC-match trigger with
//   post-trigger count, and drop accounting.
// PARAMETERS
// - NRET      1    retire lanes presented per cycle (1..4)
// - DEPTH     64   buffer entries, power of 2, >= NRET
// - XLEN      32   data/address width
// - CNT_W     16   drop counter width, saturating
// PORTS
// - clk            in   1             clock
// - reset          in   1             reset: synchronous, active-high
// - cfg_arm        in   1             pulse: flush buffer, clear counters, enter ARMED
// - cfg_disarm     in   1             pulse: go to IDLE; buffer contents kept
// - cfg_ring_mode  in   1             1=overwrite oldest on full; 0=drop newest on full
// - cfg_trig_en    in   1             enable the PC-match trigger
// - cfg_trig_pc    in   XLEN          trigger PC
// - cfg_post_cnt   in   $clog2(DEPTH)+1  entries captured after the trigger cycle
// - rvfi_valid     in   NRET          per-lane retire valid
// - rvfi_pc_rdata  in   NRET*XLEN     per-lane PC
// - rvfi_insn      in   NRET*32       per-lane instruction word
// - rvfi_rd_addr   in   NRET*5        per-lane destination register
// - rvfi_rd_wdata  in   NRET*XLEN     per-lane write-back data
// - rvfi_mem_addr  in   NRET*XLEN     per-lane memory address
// - out_valid      out  1             head entry available
// - out_ready      in   1             consumer pops the head entry when out_valid && out_ready
// - out_entry      out  trace_entry_t head record {pc, insn, rd_addr, rd_wdata, mem_addr}
// - level          out  $clog2(DEPTH)+1  occupied entries
// - drop_cnt       out  CNT_W         packets lost, saturating
// - triggered      out  1             trigger has fired since the last arm
// - state_o        out  2             trace_state_t
// BEHAVIOUR
// - Reset values: state IDLE, pointers 0, level 0, drop_cnt 0, triggered 0, out_valid 0,
//   out_entry all 0.
// - States:
//   - IDLE: no capture.
//   - ARMED: capture; watch for the trigger.
//   - POST: capture, counting entries against cfg_post_cnt.
//   - FROZEN: no capture; drain only.
// - Transitions:
//   - cfg_arm in any state -> ARMED.
//   - cfg_disarm -> IDLE. If cfg_arm and cfg_disarm are asserted together, arm wins.
//   - ARMED with trig_en and any valid lane PC == trig_pc: set triggered, then
//     -> POST, or -> FROZEN when cfg_post_cnt == 0.
//   - POST -> FROZEN once the captured post-trigger entries reach cfg_post_cnt.
// - Capture: all valid lanes in a cycle are compacted in ascending lane order into
//   consecutive slots. Written on the clock edge; the entry is visible at out_entry one cycle later.
// - Trigger cycle: every valid lane of that cycle is captured. Post counting starts on the
//   next cycle. In the final POST cycle, lanes beyond the remaining count are discarded and
//   are not counted as drops.
// - Full handling, FIFO mode: free space is DEPTH - level, using the registered level with
//   no credit for a same-cycle pop. If nwr > free, every packet of that cycle is dropped and
//   drop_cnt += nwr, saturating.
// - Full handling, ring mode: all packets are written. The overflow (level - pop + nwr - DEPTH,
//   floored at 0) advances rd_ptr. Overwrites do not count as drops.
// - Level update: level_next = min(level - pop + nwr_accepted, DEPTH).
// - Pointers: $clog2(DEPTH) bits, natural wrap-around.
// - Pop: allowed in every state. out_entry is stable while out_valid && !out_ready.
// - cfg_arm flush: level 0 and out_valid 0 on the next cycle. Capture resumes on the cycle after the arm.
// - Reset mid-capture: aborts capture; no partial entries remain.
// STRUCTURE
// - Package rvfi_trace_pkg:
//   - trace_entry_t packed struct {pc, insn, rd_addr, rd_wdata, mem_addr}.
//   - trace_state_t enum {IDLE, ARMED, POST, FROZEN}.
// - Sub-module rvfi_lane_compact: combinational prefix-sum packer. Maps the valid lanes to
//   slot offsets and outputs nwr.
// - Storage is a register array of DEPTH x trace_entry_t with NRET write ports.
// TESTING
// - NRET=1, DEPTH=8, FIFO mode. Arm, retire 10 packets with no pops ->
//   level=8, drop_cnt=2, drained PCs are the first 8 in order.
// - Same configuration in ring mode. Retire PCs 0x00..0x24 (10 packets) ->
//   level=8, drop_cnt=0, drain yields 0x08..0x24.
// - Trigger: trig_pc=0x100, post_cnt=3, retire PCs 0xF8, 0xFC, 0x100, 0x104, 0x108, 0x10C, 0x110
//   -> FROZEN after 0x10C, triggered=1, buffer ends at 0x10C.
// - NRET=2, both lanes valid every cycle, DEPTH=4, FIFO mode, level=3 ->
//   both packets dropped, drop_cnt += 2, level stays 3.
// - Simultaneous pop and write at level=DEPTH, FIFO mode -> write dropped and level=DEPTH-1.
//   Then cfg_arm while POST -> next cycle level=0, drop_cnt=0, state ARMED.
// - Assert reset mid-POST with out_ready stalled -> next cycle out_valid=0, level=0, IDLE.

Source files
------------

// File: rtl/rvfi_trace_pkg.sv
// rvfi_trace_pkg: shared types for the RVFI retirement trace buffer.
package rvfi_trace_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
    } trace_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        POST   = 2'd2,
        FROZEN = 2'd3
    } trace_state_t;

endpackage

// File: rtl/rvfi_lane_compact.sv
// rvfi_lane_compact: prefix-sum packer giving each valid lane its slot offset and the lane count.
module rvfi_lane_compact #(
    parameter int NRET = 1,
    parameter int OW   = 1
) (
    input  logic [NRET-1:0]    valid,
    output logic [NRET*OW-1:0] offset,
    output logic [OW-1:0]      nwr
);

    logic [OW-1:0] acc;

    always_comb begin
        acc    = '0;
        offset = '0;
        for (int i = 0; i < NRET; i++) begin
            offset[i*OW +: OW] = acc;
            acc = acc + OW'(valid[i]);
        end
        nwr = acc;
    end

endmodule

// File: rtl/rvfi_trace_buffer.sv
// rvfi_trace_buffer: circular capture of retired-instruction records with trigger, post-count,
// FIFO/ring full handling and saturating drop accounting; drained over a valid/ready port.
module rvfi_trace_buffer
    import rvfi_trace_pkg::*;
#(
    parameter int NRET  = 1,
    parameter int DEPTH = 64,
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_arm,
    input  logic                     cfg_disarm,
    input  logic                     cfg_ring_mode,
    input  logic                     cfg_trig_en,
    input  logic [XLEN-1:0]          cfg_trig_pc,
    input  logic [$clog2(DEPTH):0]   cfg_post_cnt,
    input  logic [NRET-1:0]          rvfi_valid,
    input  logic [NRET*XLEN-1:0]     rvfi_pc_rdata,
    input  logic [NRET*32-1:0]       rvfi_insn,
    input  logic [NRET*5-1:0]        rvfi_rd_addr,
    input  logic [NRET*XLEN-1:0]     rvfi_rd_wdata,
    input  logic [NRET*XLEN-1:0]     rvfi_mem_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output trace_entry_t             out_entry,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     triggered,
    output logic [1:0]               state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int OW = $clog2(NRET + 1);
    localparam int SW = LW + 2;
    localparam int DW = CNT_W + 1;
    localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

    trace_state_t        state, state_next;
    trace_entry_t        mem [DEPTH];
    trace_entry_t        lane [NRET];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [LW-1:0]       post_seen, post_next, remaining, level_next;
    logic [NRET-1:0]     hit, we;
    logic [NRET*OW-1:0]  offset;
    logic [OW-1:0]       nwr;
    logic [SW-1:0]       nwr_lim, nwr_acc, free, fill, over;
    logic [DW-1:0]       drop_sum;
    logic [CNT_W-1:0]    drop_next;
    logic                capture, trig_hit, post_done, do_drop, pop;

    rvfi_lane_compact #(.NRET(NRET), .OW(OW)) u_compact (
        .valid  (rvfi_valid),
        .offset (offset),
        .nwr    (nwr)
    );

    always_comb begin
        for (int i = 0; i < NRET; i++) begin
            lane[i] = '{pc:       rvfi_pc_rdata[i*XLEN +: XLEN],
                        insn:     rvfi_insn[i*32 +: 32],
                        rd_addr:  rvfi_rd_addr[i*5 +: 5],
                        rd_wdata: rvfi_rd_wdata[i*XLEN +: XLEN],
                        mem_addr: rvfi_mem_addr[i*XLEN +: XLEN]};
            hit[i]  = rvfi_valid[i] && rvfi_pc_rdata[i*XLEN +: XLEN] == cfg_trig_pc;
            we[i]   = !reset && rvfi_valid[i] && SW'(offset[i*OW +: OW]) < nwr_acc;
        end
    end

    // Config pulses take the cycle: arm flushes, disarm stops; neither captures.
    assign capture   = (state == ARMED || state == POST) && !cfg_arm && !cfg_disarm;
    assign trig_hit  = capture && state == ARMED && cfg_trig_en && |hit;
    assign remaining = cfg_post_cnt - post_seen;
    assign nwr_lim   = !capture ? '0 :
                       (state == POST && SW'(nwr) > SW'(remaining)) ? SW'(remaining) : SW'(nwr);
    assign post_done = capture && state == POST && SW'(post_seen) + nwr_lim >= SW'(cfg_post_cnt);
    assign post_next = (capture && state == POST) ? post_seen + LW'(nwr_lim) : post_seen;

    assign out_valid  = |level;
    assign pop        = out_valid && out_ready;
    assign free       = DEPTH_S - SW'(level);
    assign do_drop    = !cfg_ring_mode && nwr_lim > free;
    assign nwr_acc    = do_drop ? '0 : nwr_lim;
    // In ring mode the overflow beyond DEPTH pushes the read pointer past the oldest entries.
    assign fill       = SW'(level) - SW'(pop) + nwr_acc;
    assign over       = fill > DEPTH_S ? fill - DEPTH_S : '0;
    assign level_next = fill > DEPTH_S ? LW'(DEPTH) : LW'(fill);

    assign drop_sum  = {1'b0, drop_cnt} + DW'(nwr_lim);
    assign drop_next = !do_drop ? drop_cnt : drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];

    always_comb begin
        state_next = cfg_arm    ? ARMED :
                     cfg_disarm ? IDLE  :
                     trig_hit   ? (cfg_post_cnt == '0 ? FROZEN : POST) :
                     post_done  ? FROZEN : state;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset || cfg_arm) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            drop_cnt  <= '0;
            triggered <= 1'b0;
            post_seen <= '0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(nwr_acc);
            rd_ptr    <= rd_ptr + AW'(pop) + AW'(over);
            level     <= level_next;
            drop_cnt  <= drop_next;
            triggered <= triggered | trig_hit;
            post_seen <= post_next;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NRET; i++)
            if (we[i])
                mem[wr_ptr + AW'(offset[i*OW +: OW])] <= lane[i];
    end

    assign out_entry = out_valid ? mem[rd_ptr] : '0;
    assign state_o   = state;

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// tb_rvfi_trace_buffer: table-driven capture scenarios plus hand-written corner sequences,
// with drained entries checked against a scoreboard queue filled by a reference model.
module tb_rvfi_trace_buffer;
    import rvfi_trace_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // DUT a: NRET=1, DEPTH=8
    logic         a_arm = 0, a_disarm = 0, a_ring = 0, a_trig_en = 0, a_valid = 0, a_ready = 0;
    logic [31:0]  a_trig_pc = 0;
    logic [3:0]   a_post = 0;
    trace_entry_t a_in = '0;
    logic         a_ovalid, a_trig;
    trace_entry_t a_entry;
    logic [3:0]   a_level;
    logic [15:0]  a_drop;
    logic [1:0]   a_state;

    // DUT b: NRET=2, DEPTH=4
    logic         b_arm = 0, b_ready = 0;
    logic [1:0]   b_valid = 0;
    trace_entry_t b_in [2];
    logic         b_ovalid, b_trig;
    trace_entry_t b_entry;
    logic [2:0]   b_level;
    logic [15:0]  b_drop;
    logic [1:0]   b_state;

    rvfi_trace_buffer #(.NRET(1), .DEPTH(8), .XLEN(32), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .cfg_arm(a_arm), .cfg_disarm(a_disarm),
        .cfg_ring_mode(a_ring), .cfg_trig_en(a_trig_en), .cfg_trig_pc(a_trig_pc),
        .cfg_post_cnt(a_post), .rvfi_valid(a_valid), .rvfi_pc_rdata(a_in.pc),
        .rvfi_insn(a_in.insn), .rvfi_rd_addr(a_in.rd_addr), .rvfi_rd_wdata(a_in.rd_wdata),
        .rvfi_mem_addr(a_in.mem_addr), .out_valid(a_ovalid), .out_ready(a_ready),
        .out_entry(a_entry), .level(a_level), .drop_cnt(a_drop), .triggered(a_trig),
        .state_o(a_state)
    );

    rvfi_trace_buffer #(.NRET(2), .DEPTH(4), .XLEN(32), .CNT_W(16)) u_b (
        .clk(clk), .reset(reset), .cfg_arm(b_arm), .cfg_disarm(1'b0),
        .cfg_ring_mode(1'b0), .cfg_trig_en(1'b0), .cfg_trig_pc(32'h0),
        .cfg_post_cnt(3'd0), .rvfi_valid(b_valid),
        .rvfi_pc_rdata({b_in[1].pc, b_in[0].pc}),
        .rvfi_insn({b_in[1].insn, b_in[0].insn}),
        .rvfi_rd_addr({b_in[1].rd_addr, b_in[0].rd_addr}),
        .rvfi_rd_wdata({b_in[1].rd_wdata, b_in[0].rd_wdata}),
        .rvfi_mem_addr({b_in[1].mem_addr, b_in[0].mem_addr}),
        .out_valid(b_ovalid), .out_ready(b_ready), .out_entry(b_entry),
        .level(b_level), .drop_cnt(b_drop), .triggered(b_trig), .state_o(b_state)
    );

    int n_cmp = 0;
    int n_bad = 0;
    trace_entry_t sbq [$];

    typedef struct {
        logic         ring;
        logic         trig_en;
        logic [31:0]  trig_pc;
        logic [3:0]   post;
        int           npkt;
        logic [31:0]  base;
        int           exp_level;
        int           exp_drop;
        trace_state_t exp_state;
        logic         exp_trig;
    } vec_t;

    vec_t vt [5];

    function automatic trace_entry_t mk(input logic [31:0] pc);
        trace_entry_t e;
        e.pc       = pc;
        e.insn     = ~pc;
        e.rd_addr  = pc[6:2];
        e.rd_wdata = pc ^ 32'hA5A5_0000;
        e.mem_addr = pc + 32'h1000;
        return e;
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic arm_a(input logic ring, input logic ten, input logic [31:0] tpc,
                         input logic [3:0] post);
        @(negedge clk);
        a_ring = ring; a_trig_en = ten; a_trig_pc = tpc; a_post = post; a_arm = 1;
        @(negedge clk);
        a_arm = 0;
    endtask

    task automatic retire_a(input logic [31:0] pc);
        a_valid = 1; a_in = mk(pc);
        @(negedge clk);
        a_valid = 0;
    endtask

    // Model the buffer as a bounded queue of at most 8 entries.
    task automatic model_push(input logic ring, input trace_entry_t e);
        if (ring) begin
            sbq.push_back(e);
            if (sbq.size() > 8) sbq.delete(0);
        end else if (sbq.size() < 8) begin
            sbq.push_back(e);
        end
    endtask

    task automatic drain_a(input string name);
        int n;
        n = sbq.size();
        a_ready = 1;
        for (int k = 0; k < n; k++) begin
            chk(name, a_entry, sbq.pop_front());
            @(negedge clk);
        end
        a_ready = 0;
        chk({name, " empty"}, a_ovalid, 0);
    endtask

    initial begin
        trace_state_t ms;
        int mpost;
        logic [31:0] pc;
        b_in[0] = '0;
        b_in[1] = '0;

        vt[0] = '{0, 0, 32'h0,   4'd0, 10, 32'h0,  8, 2, ARMED,  0};
        vt[1] = '{1, 0, 32'h0,   4'd0, 10, 32'h0,  8, 0, ARMED,  0};
        vt[2] = '{0, 1, 32'h100, 4'd3, 7,  32'hF8, 6, 0, FROZEN, 1};
        vt[3] = '{0, 1, 32'h10,  4'd0, 8,  32'h0,  5, 0, FROZEN, 1};
        vt[4] = '{1, 1, 32'h20,  4'd4, 12, 32'h0,  8, 0, POST,   1};

        repeat (3) @(negedge clk);
        chk("rst state", a_state, IDLE);
        chk("rst level", a_level, 0);
        chk("rst out_valid", a_ovalid, 0);
        chk("rst out_entry", a_entry, 0);
        chk("rst drop", a_drop, 0);
        chk("rst triggered", a_trig, 0);
        chk("rst b level", b_level, 0);
        reset = 0;

        for (int s = 0; s < 5; s++) begin
            arm_a(vt[s].ring, vt[s].trig_en, vt[s].trig_pc, vt[s].post);
            sbq.delete();
            ms = ARMED;
            mpost = 0;
            for (int k = 0; k < vt[s].npkt; k++) begin
                pc = vt[s].base + 32'(4 * k);
                if (ms == ARMED) begin
                    model_push(vt[s].ring, mk(pc));
                    if (vt[s].trig_en && pc == vt[s].trig_pc)
                        ms = (vt[s].post == 0) ? FROZEN : POST;
                end else if (ms == POST) begin
                    model_push(vt[s].ring, mk(pc));
                    mpost++;
                    if (mpost == int'(vt[s].post)) ms = FROZEN;
                end
                retire_a(pc);
            end
            chk($sformatf("vec%0d level", s), a_level, vt[s].exp_level);
            chk($sformatf("vec%0d drop", s), a_drop, vt[s].exp_drop);
            chk($sformatf("vec%0d state", s), a_state, vt[s].exp_state);
            chk($sformatf("vec%0d triggered", s), a_trig, vt[s].exp_trig);
            drain_a($sformatf("vec%0d drain", s));
        end

        // Pop and write together at full in FIFO mode, then re-arm while in POST.
        arm_a(0, 1, 32'h0, 4'd15);
        for (int k = 0; k < 8; k++) retire_a(32'(4 * k));
        chk("full level", a_level, 8);
        chk("full state", a_state, POST);
        chk("stall head0", a_entry, mk(32'h0));
        @(negedge clk);
        chk("stall head1", a_entry, mk(32'h0));
        a_valid = 1; a_in = mk(32'h20); a_ready = 1;
        @(negedge clk);
        a_valid = 0; a_ready = 0;
        chk("popwr level", a_level, 7);
        chk("popwr drop", a_drop, 1);
        chk("popwr state", a_state, POST);
        chk("popwr head", a_entry, mk(32'h4));
        arm_a(0, 1, 32'h0, 4'd15);
        chk("rearm level", a_level, 0);
        chk("rearm drop", a_drop, 0);
        chk("rearm state", a_state, ARMED);
        chk("rearm out_valid", a_ovalid, 0);
        chk("rearm triggered", a_trig, 0);

        // Disarm keeps contents and stops capture; arm beats disarm.
        arm_a(0, 0, 32'h0, 4'd0);
        sbq.delete();
        retire_a(32'h200); sbq.push_back(mk(32'h200));
        retire_a(32'h204); sbq.push_back(mk(32'h204));
        a_disarm = 1;
        @(negedge clk);
        a_disarm = 0;
        chk("disarm state", a_state, IDLE);
        chk("disarm level", a_level, 2);
        retire_a(32'h208);
        chk("idle no capture", a_level, 2);
        drain_a("disarm drain");
        a_arm = 1; a_disarm = 1;
        @(negedge clk);
        a_arm = 0; a_disarm = 0;
        chk("arm wins state", a_state, ARMED);

        // Two lanes: compaction, then whole-cycle drop when nwr exceeds free space.
        b_arm = 1;
        @(negedge clk);
        b_arm = 0;
        sbq.delete();
        b_valid = 2'b10; b_in[1] = mk(32'h20); sbq.push_back(mk(32'h20));
        @(negedge clk);
        b_valid = 2'b11; b_in[0] = mk(32'h30); b_in[1] = mk(32'h34);
        sbq.push_back(mk(32'h30)); sbq.push_back(mk(32'h34));
        @(negedge clk);
        chk("b level3", b_level, 3);
        b_in[0] = mk(32'h40); b_in[1] = mk(32'h44);
        @(negedge clk);
        b_valid = 0;
        chk("b drop level", b_level, 3);
        chk("b drop cnt", b_drop, 2);
        chk("b state", b_state, ARMED);
        b_ready = 1;
        for (int k = 0; k < 3; k++) begin
            chk("b drain", b_entry, sbq.pop_front());
            @(negedge clk);
        end
        b_ready = 0;
        chk("b empty", b_ovalid, 0);

        // Reset in the middle of POST with the consumer stalled.
        arm_a(0, 1, 32'h0, 4'd15);
        retire_a(32'h0);
        retire_a(32'h4);
        chk("pre-rst state", a_state, POST);
        chk("pre-rst level", a_level, 2);
        a_ready = 0;
        reset = 1;
        @(negedge clk);
        chk("midrst out_valid", a_ovalid, 0);
        chk("midrst level", a_level, 0);
        chk("midrst state", a_state, IDLE);
        chk("midrst entry", a_entry, 0);
        reset = 0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
